lcd_write_ctrl: RTL and testbench

LCD_WRITE_CTRL -- requirements
Module: lcd_write_ctrl

---
 rtl/lcd_write_ctrl.sv | 166 ++++++++++++++++
 tb/tb_lcd_write_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_ctrl.sv
// HD44780-style LCD write controller: power-up wait, fixed four-byte init
// sequence, then single-byte requester writes with setup/enable/hold/exec timing.
module lcd_write_ctrl #(
  parameter int T_PWRUP = 1000000,
  parameter int T_SETUP = 4,
  parameter int T_EN    = 25,
  parameter int T_HOLD  = 4,
  parameter int T_EXEC  = 2500,
  parameter int T_CLEAR = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_vld,
  input  logic        req_rs,
  input  logic [7:0]  req_data,
  output logic        req_rdy,
  output logic        done,
  output logic        init_done,
  output logic [31:0] io_lcd
);

  localparam logic [19:0] C_PWRUP = 20'(T_PWRUP);
  localparam logic [19:0] C_SETUP = 20'(T_SETUP);
  localparam logic [19:0] C_EN    = 20'(T_EN);
  localparam logic [19:0] C_HOLD  = 20'(T_HOLD);
  localparam logic [19:0] C_EXEC  = 20'(T_EXEC);
  localparam logic [19:0] C_CLEAR = 20'(T_CLEAR);

  typedef enum logic [2:0] {
    PWRUP, INIT_ISSUE, IDLE, SETUP, EN_HIGH, HOLD, EXEC
  } state_t;

  state_t      state, state_nxt;
  logic [19:0] cnt, cnt_nxt;
  logic [1:0]  init_idx, init_idx_nxt;
  logic        init_done_q, init_done_nxt;
  logic        rs_q, rs_nxt;
  logic [7:0]  data_q, data_nxt;
  logic        last;
  logic        drive;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // Clear and home are the slow commands; everything else uses the short wait.
  function automatic logic [19:0] exec_len(input logic rs, input logic [7:0] d);
    if (!rs && (d == 8'h01 || d == 8'h02)) return C_CLEAR;
    return C_EXEC;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= PWRUP;
      cnt         <= C_PWRUP;
      init_idx    <= 2'd0;
      init_done_q <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      init_idx    <= init_idx_nxt;
      init_done_q <= init_done_nxt;
      rs_q        <= rs_nxt;
      data_q      <= data_nxt;
    end
  end

  assign last    = (cnt == 20'd1);
  assign req_rdy = (state == IDLE) && init_done_q;

  // INIT_ISSUE presents the next init byte with EN low, so it is also that
  // byte's setup window; init bytes then share EN_HIGH/HOLD/EXEC with requests.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt - 20'd1;
    init_idx_nxt  = init_idx;
    init_done_nxt = init_done_q;
    rs_nxt        = rs_q;
    data_nxt      = data_q;
    done          = 1'b0;
    unique case (state)
      PWRUP: begin
        if (last) begin
          state_nxt    = INIT_ISSUE;
          cnt_nxt      = C_SETUP;
          init_idx_nxt = 2'd0;
          rs_nxt       = 1'b0;
          data_nxt     = init_byte(2'd0);
        end
      end
      INIT_ISSUE, SETUP: begin
        if (last) begin
          state_nxt = EN_HIGH;
          cnt_nxt   = C_EN;
        end
      end
      IDLE: begin
        cnt_nxt = cnt;
        if (req_vld && req_rdy) begin
          state_nxt = SETUP;
          cnt_nxt   = C_SETUP;
          rs_nxt    = req_rs;
          data_nxt  = req_data;
        end
      end
      EN_HIGH: begin
        if (last) begin
          state_nxt = HOLD;
          cnt_nxt   = C_HOLD;
        end
      end
      HOLD: begin
        if (last) begin
          state_nxt = EXEC;
          cnt_nxt   = exec_len(rs_q, data_q);
        end
      end
      EXEC: begin
        if (last) begin
          if (init_done_q) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else if (init_idx == 2'd3) begin
            state_nxt     = IDLE;
            init_done_nxt = 1'b1;
          end else begin
            state_nxt    = INIT_ISSUE;
            cnt_nxt      = C_SETUP;
            init_idx_nxt = init_idx + 2'd1;
            rs_nxt       = 1'b0;
            data_nxt     = init_byte(init_idx + 2'd1);
          end
        end
      end
      default: begin
        state_nxt = PWRUP;
        cnt_nxt   = C_PWRUP;
      end
    endcase
  end

  assign init_done = init_done_q;
  assign drive     = (state == INIT_ISSUE) || (state == SETUP) ||
                     (state == EN_HIGH) || (state == HOLD);

  // Pins are gated by rst directly so EN drops the instant reset asserts.
  always_comb begin
    io_lcd = 32'h0;
    if (!rst) begin
      io_lcd[31] = 1'b1;
      io_lcd[10] = (state == EN_HIGH);
      if (drive) begin
        io_lcd[9]   = rs_q;
        io_lcd[7:0] = data_q;
      end
    end
  end

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Directed bench for lcd_write_ctrl with shortened timing parameters.
module tb_lcd_write_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_vld = 1'b0;
  logic        req_rs = 1'b0;
  logic [7:0]  req_data = 8'h00;
  logic        req_rdy;
  logic        done;
  logic        init_done;
  logic [31:0] io_lcd;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  lcd_write_ctrl #(
    .T_PWRUP(4), .T_SETUP(1), .T_EN(2), .T_HOLD(1), .T_EXEC(3), .T_CLEAR(6)
  ) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rs(req_rs),
    .req_data(req_data), .req_rdy(req_rdy), .done(done),
    .init_done(init_done), .io_lcd(io_lcd)
  );

  always #5 clk = ~clk;

  // Per-cycle pin invariants and done-pulse tally.
  always @(negedge clk) begin
    checks++;
    if (rst) begin
      if (io_lcd !== 32'h0) begin
        failures++;
        $display("FAIL pins_in_reset: got %h expected 00000000", io_lcd);
      end
    end else if (io_lcd[31] !== 1'b1 || io_lcd[30:11] !== 20'h0 || io_lcd[8] !== 1'b0) begin
      failures++;
      $display("FAIL pin_invariants: got %h expected ON=1 RW=0 [30:11]=0", io_lcd);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (io_lcd !== 32'h0 || req_rdy !== 1'b0 || done !== 1'b0 || init_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got io=%h rdy=%b done=%b init=%b expected all 0",
               io_lcd, req_rdy, done, init_done);
    end
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_power_up_init();
    logic [7:0] init_b [4];
    logic [10:0] exp_low;
    logic exp_en, exp_drv, exp_rdy;
    logic [7:0] exp_byte;
    int c, s, len, off, d0;
    init_b[0] = 8'h38; init_b[1] = 8'h0C; init_b[2] = 8'h01; init_b[3] = 8'h06;
    d0 = done_cnt;
    for (int e = 0; e <= 36; e++) begin
      if (e > 0) begin
        @(posedge clk);
        #1;
      end
      c = e + 1;
      exp_en = 1'b0; exp_drv = 1'b0; exp_byte = 8'h00;
      s = 5;
      for (int k = 0; k < 4; k++) begin
        len = (k == 2) ? 10 : 7;
        if (c >= s && c < s + len) begin
          off = c - s;
          exp_en   = (off >= 1 && off <= 2);
          exp_drv  = (off <= 3);
          exp_byte = init_b[k];
        end
        s += len;
      end
      exp_low = {exp_en, 1'b0, 1'b0, exp_drv ? exp_byte : 8'h00};
      exp_rdy = (c >= 36);
      checks++;
      if (io_lcd[10:0] !== exp_low) begin
        failures++;
        $display("FAIL init_pins cycle %0d: got %h expected %h", c, io_lcd[10:0], exp_low);
      end
      checks++;
      if (req_rdy !== exp_rdy || init_done !== exp_rdy) begin
        failures++;
        $display("FAIL init_rdy cycle %0d: got rdy=%b init=%b expected %b",
                 c, req_rdy, init_done, exp_rdy);
      end
    end
    checks++;
    if (done_cnt != d0) begin
      failures++;
      $display("FAIL init_no_done: got %0d pulses expected 0", done_cnt - d0);
    end
  endtask

  task automatic test_write(input logic rs, input logic [7:0] d, input int exec_l,
                            input string name);
    int w, lat, d0;
    logic [10:0] exp_low;
    logic drv;
    w = 0;
    while (req_rdy !== 1'b1 && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    checks++;
    if (w >= 100) begin
      failures++;
      $display("FAIL %s_wait_rdy: got rdy=%b expected 1 within 100 cycles", name, req_rdy);
    end
    d0 = done_cnt;
    req_vld = 1'b1; req_rs = rs; req_data = d;
    @(posedge clk);
    #1;
    req_vld = 1'b0; req_rs = ~rs; req_data = ~d;
    lat = 4 + exec_l;
    for (int j = 0; j <= lat; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      drv = (j <= 3);
      exp_low = {(j >= 1 && j <= 2), drv ? rs : 1'b0, 1'b0, drv ? d : 8'h00};
      checks++;
      if (io_lcd[10:0] !== exp_low) begin
        failures++;
        $display("FAIL %s_pins step %0d: got %h expected %h", name, j, io_lcd[10:0], exp_low);
      end
      checks++;
      if (done !== (j == lat - 1) || req_rdy !== (j >= lat)) begin
        failures++;
        $display("FAIL %s_ctrl step %0d: got done=%b rdy=%b expected done=%b rdy=%b",
                 name, j, done, req_rdy, (j == lat - 1), (j >= lat));
      end
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL %s_done_count: got %0d expected 1", name, done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4];
    logic [7:0] got_q [$];
    logic prev_en, accept_now;
    int acc, d0;
    bytes[0] = 8'h48; bytes[1] = 8'h49; bytes[2] = 8'h21; bytes[3] = 8'h7E;
    acc = 0; prev_en = 1'b0; d0 = done_cnt;
    req_vld = 1'b1; req_rs = 1'b1; req_data = bytes[0];
    for (int cyc = 0; cyc < 50; cyc++) begin
      accept_now = req_vld && req_rdy;
      @(posedge clk);
      #1;
      if (accept_now) begin
        acc++;
        if (acc < 4) req_data = bytes[acc];
        else req_vld = 1'b0;
      end
      if (io_lcd[10] && !prev_en) got_q.push_back(io_lcd[7:0]);
      prev_en = io_lcd[10];
    end
    req_vld = 1'b0;
    checks++;
    if (acc != 4 || got_q.size() != 4) begin
      failures++;
      $display("FAIL b2b_counts: got accepted=%0d written=%0d expected 4/4", acc, got_q.size());
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== bytes[i]) begin
        failures++;
        $display("FAIL b2b_byte %0d: got %h expected %h", i, got_q[i], bytes[i]);
      end
    end
    checks++;
    if (done_cnt - d0 != 4) begin
      failures++;
      $display("FAIL b2b_done_count: got %0d expected 4", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    int w, d0;
    w = 0;
    while (req_rdy !== 1'b1 && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    req_vld = 1'b1; req_rs = 1'b1; req_data = 8'h55;
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (io_lcd[10] !== 1'b1) begin
      failures++;
      $display("FAIL midrst_en_before: got EN=%b expected 1", io_lcd[10]);
    end
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (io_lcd !== 32'h0 || req_rdy !== 1'b0 || done !== 1'b0 || init_done !== 1'b0) begin
      failures++;
      $display("FAIL midrst_outputs: got io=%h rdy=%b done=%b init=%b expected all 0",
               io_lcd, req_rdy, done, init_done);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    for (int e = 0; e <= 35; e++) begin
      if (e > 0) begin
        @(posedge clk);
        #1;
      end
      if (e == 4 || e == 5) begin
        checks++;
        if (io_lcd[10] !== (e == 5)) begin
          failures++;
          $display("FAIL midrst_init_en cycle %0d: got %b expected %b", e + 1, io_lcd[10], (e == 5));
        end
      end
      if (e == 34 || e == 35) begin
        checks++;
        if (req_rdy !== (e == 35)) begin
          failures++;
          $display("FAIL midrst_rdy cycle %0d: got %b expected %b", e + 1, req_rdy, (e == 35));
        end
      end
    end
    checks++;
    if (done_cnt != d0) begin
      failures++;
      $display("FAIL midrst_no_done: got %0d pulses expected 0", done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_power_up_init();
    test_write(1'b1, 8'h41, 3, "data_41");
    test_write(1'b0, 8'h01, 6, "cmd_clear");
    test_write(1'b1, 8'h01, 3, "data_01");
    test_write(1'b0, 8'h02, 6, "cmd_home");
    test_write(1'b0, 8'h38, 3, "cmd_func");
    test_back_to_back();
    test_reset_mid();
    test_write(1'b1, 8'h5A, 3, "post_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
